// File: rtl/opg_frame_sched_pkg.sv
// Shared types and defaults for the OPG frame scheduler.
package opg_frame_sched_pkg;

    localparam int unsigned FRAME_LEN_DEF   = 4320;
    localparam int unsigned GAP_CYC_DEF     = 4;
    localparam int unsigned TIMEOUT_CYC_DEF = 16;
    localparam int unsigned CNT_W           = 13;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        START  = 3'd2,
        STREAM = 3'd3,
        GAP    = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; pointer moves only on the advance strobe.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic last;  // 1 when requester 1 was served most recently

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (adv && (gnt != 2'b00)) begin
            last <= gnt[1];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/opg_frame_sched.sv
// Schedules payload-generator frames between two requesters and routes the bit stream.
module opg_frame_sched
    import opg_frame_sched_pkg::*;
#(
    parameter int unsigned FRAME_LEN   = FRAME_LEN_DEF,
    parameter int unsigned GAP_CYC     = GAP_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       opg_rd_en,
    input  logic       opg_do,
    input  logic       opg_do_vld,
    output logic       pl_data,
    output logic [1:0] pl_vld,
    output logic [1:0] frame_done,
    output logic       busy,
    input  logic       err_clr,
    output logic       err_timeout,
    output logic       err_short
);

    localparam int unsigned TMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [TW-1:0]    tcnt, tcnt_d;
    logic [1:0]       gnt_d, arb_gnt;
    logic             adv, done_c, set_to, set_sh, in_frame;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .adv (adv),
        .gnt (arb_gnt)
    );

    assign in_frame = (state == START) || (state == STREAM);

    // Next state, beat counter and shared wait/gap timer.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        tcnt_d  = tcnt;
        gnt_d   = gnt;
        adv     = 1'b0;
        done_c  = 1'b0;
        set_to  = 1'b0;
        set_sh  = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) state_d = ARB;
            end
            ARB: begin
                adv    = 1'b1;
                cnt_d  = '0;
                tcnt_d = '0;
                if (arb_gnt != 2'b00) begin
                    gnt_d   = arb_gnt;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START, STREAM: begin
                if (opg_do_vld) begin
                    if (cnt == LAST_BIT) begin
                        done_c  = 1'b1;
                        state_d = GAP;
                    end else begin
                        cnt_d   = cnt + 1'b1;
                        state_d = STREAM;
                    end
                end else if (state == STREAM) begin
                    set_sh  = 1'b1;
                    state_d = GAP;
                end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    set_to  = 1'b1;
                    state_d = GAP;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            GAP: begin
                if (tcnt == TW'(GAP_CYC - 1)) state_d = IDLE;
                else                           tcnt_d  = tcnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Grant is released and the timer restarts as the gap begins.
        if ((state_d == GAP) && (state != GAP)) begin
            gnt_d  = 2'b00;
            tcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            tcnt        <= '0;
            gnt         <= 2'b00;
            opg_rd_en   <= 1'b0;
            busy        <= 1'b0;
            pl_data     <= 1'b0;
            pl_vld      <= 2'b00;
            frame_done  <= 2'b00;
            err_timeout <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            tcnt        <= tcnt_d;
            gnt         <= gnt_d;
            opg_rd_en   <= (state_d == START) || (state_d == STREAM);
            busy        <= (state_d != IDLE);
            pl_data     <= opg_do;
            pl_vld      <= (in_frame && opg_do_vld) ? gnt : 2'b00;
            frame_done  <= done_c ? gnt : 2'b00;
            err_timeout <= err_clr ? 1'b0 : (err_timeout | set_to);
            err_short   <= err_clr ? 1'b0 : (err_short | set_sh);
        end
    end

endmodule
